instr_fetch_unit: RTL and testbench

//  Fetch-side producer for the instruction register: owns the program counter, reads one

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_pc.sv | 39 +++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the fetch unit and the instruction register side:
//   fetch FSM state encodings and default word/address widths.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int DEF_INSTR_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOAD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Instruction memory read bus between the fetch unit (master) and the
//   instruction memory (slave).
//   mem_req   : one-cycle read request
//   mem_addr  : read address
//   mem_ack   : read data valid this cycle
//   mem_rdata : read data, valid with mem_ack
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);

  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/instr_fetch_unit_pc.sv
// -----------------------------------------------------------------------------
// program_counter
//   Program counter register with load and increment.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (pc <= RESET_PC)
//   ld     : load ld_val (has priority over inc)
//   ld_val : load value
//   inc    : increment by one, wrapping modulo 2^ADDR_WIDTH
//   pc     : current program counter
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [ADDR_WIDTH-1:0] ld_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (ld) begin
      r_pc <= ld_val;
    end else if (inc) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);  // natural wrap at 2^ADDR_WIDTH
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the PC, issues one instruction memory read per fetch request and
//   delivers the word to the instruction register with a one-cycle load
//   strobe. Supports PC redirect with squash of an in-flight read and a
//   bounded memory wait that reports a timeout.
//   clk, rst   : clock, synchronous active-high reset
//   fetch_req  : request one fetch (sampled only in IDLE)
//   pc_ld/pc_in: PC redirect
//   mem        : instruction memory read bus (master side)
//   instr_out  : fetched instruction, IR_ld : IR load strobe
//   pc_out     : current PC
//   fetch_busy : not IDLE, fetch_done : pulse with IR_ld,
//   fetch_err  : pulse on memory timeout
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic                   pc_ld,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  instr_fetch_unit_if.master     mem,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   IR_ld,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   fetch_busy,
  output logic                   fetch_done,
  output logic                   fetch_err
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  // Value of the wait counter during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t           r_state;
  fetch_state_t           w_state_nxt;
  logic                   r_squash;
  logic [CNT_W-1:0]       r_wait_cnt;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_fetch_err;
  logic                   w_capture;
  logic                   w_timeout;
  logic                   w_pc_inc;
  logic [ADDR_WIDTH-1:0]  w_pc;

  assign w_pc_inc = (r_state == ST_LOAD);

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .ld     (pc_ld),
    .ld_val (pc_in),
    .inc    (w_pc_inc),
    .pc     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:  if (fetch_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem.mem_ack) begin
          // A redirect seen earlier (squash) or in this very cycle makes the
          // returning word stale: drop it and refetch at the new PC.
          if (r_squash || pc_ld) begin
            w_state_nxt = ST_ISSUE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash    <= 1'b0;
      r_wait_cnt  <= '0;
      r_instr     <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      // Registered so the error pulse lands in the first IDLE cycle.
      r_fetch_err <= w_timeout;

      if (w_capture) r_instr <= mem.mem_rdata;

      if (r_state == ST_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT && !mem.mem_ack) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      // Squash is consumed by the next ack or abandoned on timeout.
      if (r_state == ST_WAIT && (mem.mem_ack || w_timeout)) begin
        r_squash <= 1'b0;
      end else if (pc_ld && (r_state == ST_ISSUE || r_state == ST_WAIT)) begin
        r_squash <= 1'b1;
      end
    end
  end

  assign mem.mem_req  = (r_state == ST_ISSUE);
  assign mem.mem_addr = w_pc;
  assign instr_out    = r_instr;
  assign IR_ld        = (r_state == ST_LOAD);
  assign fetch_done   = (r_state == ST_LOAD);
  assign fetch_busy   = (r_state != ST_IDLE);
  assign fetch_err    = r_fetch_err;
  assign pc_out       = w_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. The bench plays instruction memory;
//   every word that should reach the instruction register is pushed to a
//   scoreboard queue when its ack is driven and popped when IR_ld is seen.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int IW   = 16;
  localparam int AW   = 8;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic          pc_ld = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [IW-1:0] instr_out;
  logic          IR_ld;
  logic [AW-1:0] pc_out;
  logic          fetch_busy;
  logic          fetch_done;
  logic          fetch_err;

  instr_fetch_unit_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) mem_if ();

  instr_fetch_unit #(
    .INSTR_WIDTH (IW),
    .ADDR_WIDTH  (AW),
    .RESET_PC    ('0),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc_ld      (pc_ld),
    .pc_in      (pc_in),
    .mem        (mem_if),
    .instr_out  (instr_out),
    .IR_ld      (IR_ld),
    .pc_out     (pc_out),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_req   = 0;
  int            n_ld    = 0;
  logic [IW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: count requests, score every IR load.
  always @(negedge clk) begin
    if (mem_if.mem_req) n_req++;
    if (IR_ld) begin
      n_ld++;
      if (sb.size() == 0) chk("ir_ld_unexpected", 32'(IR_ld), 32'(0));
      else                chk("sb_instr", 32'(instr_out), 32'(sb.pop_front()));
    end
  end

  // One complete fetch with the ack in the first WAIT cycle.
  task automatic fetch_ok(input string tag, input logic [AW-1:0] exp_addr,
                          input logic [IW-1:0] data);
    fetch_req = 1'b1;
    tick(1);                                  // ISSUE
    fetch_req = 1'b0;
    chk({tag, "_mem_req"},  32'(mem_if.mem_req),  32'(1));
    chk({tag, "_mem_addr"}, 32'(mem_if.mem_addr), 32'(exp_addr));
    tick(1);                                  // WAIT
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = data;
    sb.push_back(data);
    tick(1);                                  // LOAD
    mem_if.mem_ack   = 1'b0;
    chk({tag, "_ir_ld"},      32'(IR_ld),      32'(1));
    chk({tag, "_fetch_done"}, 32'(fetch_done), 32'(1));
    chk({tag, "_instr_out"},  32'(instr_out),  32'(data));
    tick(1);                                  // IDLE
    chk({tag, "_idle"}, 32'(fetch_busy), 32'(0));
  endtask

  initial begin
    int req_base;
    int waited;

    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;

    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst_pc_out",     32'(pc_out),         32'(0));
    chk("rst_instr_out",  32'(instr_out),      32'(0));
    chk("rst_ir_ld",      32'(IR_ld),          32'(0));
    chk("rst_mem_req",    32'(mem_if.mem_req), 32'(0));
    chk("rst_busy",       32'(fetch_busy),     32'(0));
    chk("rst_fetch_err",  32'(fetch_err),      32'(0));
    chk("rst_fetch_done", 32'(fetch_done),     32'(0));

    // Basic fetch at PC=0
    req_base = n_req;
    fetch_ok("basic", 8'h00, 16'hA5C3);
    chk("basic_pc_out",  32'(pc_out),         32'(8'h01));
    chk("basic_one_req", 32'(n_req - req_base), 32'(1));

    // PC wrap from 0xFF
    pc_ld = 1'b1; pc_in = 8'hFF;
    tick(1);
    pc_ld = 1'b0;
    chk("wrap_pc_loaded", 32'(pc_out), 32'(8'hFF));
    fetch_ok("wrap", 8'hFF, 16'hBEEF);
    chk("wrap_pc_out", 32'(pc_out), 32'(8'h00));

    // Squash: redirect during WAIT, stale word dropped, refetch at new PC
    pc_ld = 1'b1; pc_in = 8'h04;
    tick(1);
    pc_ld = 1'b0;
    fetch_req = 1'b1;
    tick(1);                                  // ISSUE
    fetch_req = 1'b0;
    chk("sq_addr1", 32'(mem_if.mem_addr), 32'(8'h04));
    tick(1);                                  // WAIT
    pc_ld = 1'b1; pc_in = 8'h20;
    tick(1);                                  // still WAIT, squash armed
    pc_ld = 1'b0;
    chk("sq_pc_redirect", 32'(pc_out),     32'(8'h20));
    chk("sq_busy",        32'(fetch_busy), 32'(1));
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1111;   // stale, not scored
    tick(1);                                  // back to ISSUE
    mem_if.mem_ack = 1'b0;
    chk("sq_ir_ld_none", 32'(IR_ld),           32'(0));
    chk("sq_req2",       32'(mem_if.mem_req),  32'(1));
    chk("sq_addr2",      32'(mem_if.mem_addr), 32'(8'h20));
    tick(1);                                  // WAIT
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h2222;
    sb.push_back(16'h2222);
    tick(1);                                  // LOAD
    mem_if.mem_ack = 1'b0;
    chk("sq_instr_out", 32'(instr_out), 32'(16'h2222));
    tick(1);
    chk("sq_pc_out", 32'(pc_out), 32'(8'h21));

    // Timeout: no ack for MAX_WAIT WAIT cycles
    fetch_req = 1'b1;
    tick(1);                                  // ISSUE
    fetch_req = 1'b0;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      waited++;
      if (fetch_err) break;
    end
    chk("to_err_seen",  32'(fetch_err),  32'(1));
    chk("to_cycles",    32'(waited),     32'(MAXW + 1));
    chk("to_idle",      32'(fetch_busy), 32'(0));
    chk("to_pc_out",    32'(pc_out),     32'(8'h21));
    chk("to_instr_out", 32'(instr_out),  32'(16'h2222));
    tick(1);
    chk("to_err_pulse", 32'(fetch_err),  32'(0));

    // Reset mid-WAIT; a late ack must not load the IR
    pc_ld = 1'b1; pc_in = 8'h07;
    tick(1);
    pc_ld = 1'b0;
    fetch_req = 1'b1;
    tick(1);                                  // ISSUE
    fetch_req = 1'b0;
    tick(2);                                  // WAIT
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("mrst_pc_out",    32'(pc_out),         32'(0));
    chk("mrst_instr_out", 32'(instr_out),      32'(0));
    chk("mrst_busy",      32'(fetch_busy),     32'(0));
    chk("mrst_mem_req",   32'(mem_if.mem_req), 32'(0));
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hDEAD;
    tick(1);
    mem_if.mem_ack = 1'b0;
    tick(1);
    chk("mrst_late_ack_ir", 32'(IR_ld),     32'(0));
    chk("mrst_late_ack_io", 32'(instr_out), 32'(0));

    // Collisions: fetch_req held high while busy, pc_ld in LOAD
    req_base  = n_req;
    fetch_req = 1'b1;
    tick(1);                                  // ISSUE
    chk("col_addr", 32'(mem_if.mem_addr), 32'(8'h00));
    tick(1);                                  // WAIT
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h3C3C;
    sb.push_back(16'h3C3C);
    tick(1);                                  // LOAD
    mem_if.mem_ack = 1'b0;
    pc_ld = 1'b1; pc_in = 8'h40;
    chk("col_ir_ld", 32'(IR_ld), 32'(1));
    tick(1);                                  // IDLE
    pc_ld     = 1'b0;
    fetch_req = 1'b0;
    chk("col_pc_out",    32'(pc_out),    32'(8'h40));
    chk("col_instr_out", 32'(instr_out), 32'(16'h3C3C));
    tick(1);
    chk("col_idle",     32'(fetch_busy),        32'(0));
    chk("col_one_req",  32'(n_req - req_base),  32'(1));

    // Scoreboard drained, every expected load seen
    chk("sb_empty",    32'(sb.size()), 32'(0));
    chk("ir_ld_total", 32'(n_ld),      32'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 200000");
    $fatal(1);
  end

endmodule
